id_stage_pipe: RTL and testbench

Parametrised instruction-decode stage for the 5-stage MIPS pipeline. It contains:
- the register file;
- the main control decoder;
- load-use and branch-operand hazard detection;
- branch/jump resolution in ID;
- the ID/EX pipeline register.

It sits between the IF/ID register and EX. It drives the PC/IF-ID write enables and the flush back to IF.

---
 rtl/id_stage_pipe.sv | 176 +++++++++++++++++
 tb/tb_id_stage_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: register file, control decode, hazard detection, ID branch resolution and ID/EX register.
// Define BRANCH_FWD_EN to forward MEM non-load results into the beq compare instead of stalling.
module id_stage_pipe #(
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   if_valid,
   input  logic [31:0]            instruction,
   input  logic [DATA_W-1:0]      pc_4,
   input  logic                   wb_reg_write,
   input  logic [REG_ADDR_W-1:0]  wb_reg,
   input  logic [DATA_W-1:0]      wb_data,
   input  logic                   mem_reg_write,
   input  logic                   mem_mem_read,
   input  logic [REG_ADDR_W-1:0]  mem_reg,
   input  logic [DATA_W-1:0]      mem_alu_result,
   output logic                   pc_write,
   output logic                   ifid_write,
   output logic                   flush,
   output logic                   branch_taken,
   output logic [DATA_W-1:0]      branch_target,
   output logic                   ex_valid,
   output logic                   ex_reg_write,
   output logic                   ex_mem_to_reg,
   output logic                   ex_mem_read,
   output logic                   ex_mem_write,
   output logic                   ex_alu_src,
   output logic                   ex_reg_dst,
   output logic [1:0]             ex_alu_op,
   output logic [REG_ADDR_W-1:0]  ex_reg_rs,
   output logic [REG_ADDR_W-1:0]  ex_reg_rt,
   output logic [REG_ADDR_W-1:0]  ex_reg_rd,
   output logic [DATA_W-1:0]      ex_imm,
   output logic [DATA_W-1:0]      ex_rs_data,
   output logic [DATA_W-1:0]      ex_rt_data,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam int NREGS = 1 << REG_ADDR_W;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                          OP_ADDI  = 6'h08, OP_BEQ = 6'h04, OP_J = 6'h02;
`ifdef BRANCH_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic                  valid;
      logic                  regWrite;
      logic                  memToReg;
      logic                  memRead;
      logic                  memWrite;
      logic                  aluSrc;
      logic                  regDst;
      logic [1:0]            aluOp;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     imm;
      logic [DATA_W-1:0]     rsData;
      logic [DATA_W-1:0]     rtData;
   } idEx_t;

   logic [DATA_W-1:0]     regFile [NREGS];
   logic [5:0]            opcode;
   logic [REG_ADDR_W-1:0] rs, rt, rd, exDst;
   logic                  isBeq, isJ, rtUsed;
   logic [DATA_W-1:0]     rsData, rtData, rsCmp, rtCmp, immExt, beqTarget, jTarget;
   logic                  rsMemHit, rtMemHit, rsStall, rtStall, rsFwd, rtFwd;
   logic                  loadUse, stall, take;
   idEx_t                 exReg, exNext;

   assign opcode = instruction[31:26];
   assign rs     = REG_ADDR_W'(instruction[25:21]);
   assign rt     = REG_ADDR_W'(instruction[20:16]);
   assign rd     = REG_ADDR_W'(instruction[15:11]);
   assign isBeq  = (opcode == OP_BEQ);
   assign isJ    = (opcode == OP_J);
   assign rtUsed = (opcode == OP_RTYPE) || (opcode == OP_SW) || isBeq;
   assign immExt = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

   // Register reads see a same-cycle WB write
   assign rsData = (rs == '0) ? '0 : (wb_reg_write && wb_reg == rs) ? wb_data : regFile[rs];
   assign rtData = (rt == '0) ? '0 : (wb_reg_write && wb_reg == rt) ? wb_data : regFile[rt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
      end else if (wb_reg_write && wb_reg != '0) begin
         regFile[wb_reg] <= wb_data;
      end
   end

   assign exDst    = ex_reg_dst ? ex_reg_rd : ex_reg_rt;
   assign loadUse  = ex_valid && ex_mem_read && ex_reg_rt != '0 &&
                     (ex_reg_rt == rs || (rtUsed && ex_reg_rt == rt));
   assign rsMemHit = mem_reg_write && rs == mem_reg;
   assign rtMemHit = mem_reg_write && rt == mem_reg;
   assign rsStall  = rs != '0 && ((ex_valid && ex_reg_write && rs == exDst) ||
                                  (rsMemHit && (mem_mem_read || !FWD)));
   assign rtStall  = rt != '0 && ((ex_valid && ex_reg_write && rt == exDst) ||
                                  (rtMemHit && (mem_mem_read || !FWD)));
   assign rsFwd    = FWD && rs != '0 && rsMemHit && !mem_mem_read;
   assign rtFwd    = FWD && rt != '0 && rtMemHit && !mem_mem_read;
   assign rsCmp    = rsFwd ? mem_alu_result : rsData;
   assign rtCmp    = rtFwd ? mem_alu_result : rtData;

   // Reset forces the IF-facing controls to their idle values
   assign stall = rst_n && if_valid && (loadUse || (isBeq && (rsStall || rtStall)));
   assign take  = rst_n && if_valid && !stall && (isJ || (isBeq && rsCmp == rtCmp));

   assign beqTarget     = pc_4 + {immExt[DATA_W-3:0], 2'b00};
   assign jTarget       = {pc_4[DATA_W-1:28], instruction[25:0], 2'b00};
   assign pc_write      = !stall;
   assign ifid_write    = !stall;
   assign branch_taken  = take;
   assign flush         = take;
   assign branch_target = isJ ? jTarget : beqTarget;

   always_comb begin
      exNext = '0;
      if (if_valid && !stall) begin
         exNext.valid  = 1'b1;
         exNext.rs     = rs;
         exNext.rt     = rt;
         exNext.rd     = rd;
         exNext.imm    = immExt;
         exNext.rsData = rsData;
         exNext.rtData = rtData;
         case (opcode)
            OP_RTYPE: begin
               exNext.regDst = 1'b1; exNext.regWrite = 1'b1; exNext.aluOp = 2'b10;
            end
            OP_LW: begin
               exNext.aluSrc = 1'b1; exNext.memToReg = 1'b1;
               exNext.regWrite = 1'b1; exNext.memRead = 1'b1;
            end
            OP_SW:   begin exNext.aluSrc = 1'b1; exNext.memWrite = 1'b1; end
            OP_ADDI: begin exNext.aluSrc = 1'b1; exNext.regWrite = 1'b1; end
            OP_BEQ:  exNext.aluOp = 2'b01;
            default: ;
         endcase
      end
   end

   // ID/EX boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exReg       <= '0;
         stall_count <= '0;
      end else begin
         exReg <= exNext;
         if (stall && stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
      end
   end

   assign ex_valid      = exReg.valid;
   assign ex_reg_write  = exReg.regWrite;
   assign ex_mem_to_reg = exReg.memToReg;
   assign ex_mem_read   = exReg.memRead;
   assign ex_mem_write  = exReg.memWrite;
   assign ex_alu_src    = exReg.aluSrc;
   assign ex_reg_dst    = exReg.regDst;
   assign ex_alu_op     = exReg.aluOp;
   assign ex_reg_rs     = exReg.rs;
   assign ex_reg_rt     = exReg.rt;
   assign ex_reg_rd     = exReg.rd;
   assign ex_imm        = exReg.imm;
   assign ex_rs_data    = exReg.rsData;
   assign ex_rt_data    = exReg.rtData;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: decode table, directed hazard/branch sequences and a randomized run
// checked against a rule-level reference model. Honours BRANCH_FWD_EN like the design.
module tb_id_stage_pipe;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;
`ifdef BRANCH_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_valid;
   logic [31:0]   instruction;
   logic [DW-1:0] pc_4;
   logic          wb_reg_write;
   logic [AW-1:0] wb_reg;
   logic [DW-1:0] wb_data;
   logic          mem_reg_write, mem_mem_read;
   logic [AW-1:0] mem_reg;
   logic [DW-1:0] mem_alu_result;
   logic          pc_write, ifid_write, flush, branch_taken;
   logic [DW-1:0] branch_target;
   logic          ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
   logic [1:0]    ex_alu_op;
   logic [AW-1:0] ex_reg_rs, ex_reg_rt, ex_reg_rd;
   logic [DW-1:0] ex_imm, ex_rs_data, ex_rt_data;
   logic [CW-1:0] stall_count;

   always #5 clk = ~clk;

   id_stage_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instruction(instruction), .pc_4(pc_4),
      .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_reg(mem_reg),
      .mem_alu_result(mem_alu_result), .pc_write(pc_write), .ifid_write(ifid_write), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
      .ex_alu_op(ex_alu_op), .ex_reg_rs(ex_reg_rs), .ex_reg_rt(ex_reg_rt), .ex_reg_rd(ex_reg_rd),
      .ex_imm(ex_imm), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .stall_count(stall_count)
   );

   typedef struct packed {
      logic valid, regWrite, memToReg, memRead, memWrite, aluSrc, regDst;
      logic [1:0]  aluOp;
      logic [4:0]  rs, rt, rd;
      logic [31:0] imm, rsData, rtData;
   } exrec_t;

   typedef struct packed {
      logic [31:0] ins;
      logic [8:0]  expCtrl;   // {valid,regWrite,memToReg,memRead,memWrite,aluSrc,regDst,aluOp}
      logic        expTaken;
   } vec_t;

   logic [31:0] rf [32];
   exrec_t      mEx;
   int          mCnt;
   int          nCmp = 0;
   int          nBad = 0;
   logic        sPcWrite, sIfid, sTaken, sFlush;
   logic [31:0] sTarget;
   logic [31:0] rIns;
   vec_t        vecs [7];
   logic [5:0]  ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02, 6'h3F};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] regVal(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_reg_write && wb_reg == r) return wb_data;
      return rf[r];
   endfunction

   // Reference: expected stall/branch for the current inputs and the record ID/EX should capture
   task automatic predict(output logic st, output logic tk, output logic [31:0] tg, output exrec_t nx);
      logic [5:0]  op;
      logic [4:0]  s, t, r, exDst;
      logic        useRt, lu, bs;
      logic [31:0] a, b;
      op = instruction[31:26]; s = instruction[25:21]; t = instruction[20:16];
      useRt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      lu = if_valid && mEx.valid && mEx.memRead && mEx.rt != 0 && (mEx.rt == s || (useRt && mEx.rt == t));
      bs = 1'b0;
      a = regVal(s);
      b = regVal(t);
      exDst = mEx.regDst ? mEx.rd : mEx.rt;
      if (if_valid && op == 6'h04) begin
         for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? s : t;
            if (r != 0) begin
               if (mEx.valid && mEx.regWrite && r == exDst) bs = 1'b1;
               if (mem_reg_write && r == mem_reg) begin
                  if (mem_mem_read || !FWD) bs = 1'b1;
                  else if (k == 0) a = mem_alu_result;
                  else b = mem_alu_result;
               end
            end
         end
      end
      st = lu || bs;
      tk = if_valid && !st && ((op == 6'h04 && a == b) || op == 6'h02);
      tg = (op == 6'h02) ? {pc_4[31:28], instruction[25:0], 2'b00}
                         : pc_4 + ({{16{instruction[15]}}, instruction[15:0]} << 2);
      nx = '0;
      if (if_valid && !st) begin
         nx.valid = 1'b1;
         nx.rs = s; nx.rt = t; nx.rd = instruction[15:11];
         nx.imm = {{16{instruction[15]}}, instruction[15:0]};
         nx.rsData = regVal(s);
         nx.rtData = regVal(t);
         case (op)
            6'h00: begin nx.regDst = 1; nx.regWrite = 1; nx.aluOp = 2'b10; end
            6'h23: begin nx.aluSrc = 1; nx.memToReg = 1; nx.regWrite = 1; nx.memRead = 1; end
            6'h2B: begin nx.aluSrc = 1; nx.memWrite = 1; end
            6'h08: begin nx.aluSrc = 1; nx.regWrite = 1; end
            6'h04: nx.aluOp = 2'b01;
            default: ;
         endcase
      end
   endtask

   task automatic checkEx();
      chk("ex_valid", ex_valid, mEx.valid);
      chk("ex_reg_write", ex_reg_write, mEx.regWrite);
      chk("ex_mem_to_reg", ex_mem_to_reg, mEx.memToReg);
      chk("ex_mem_read", ex_mem_read, mEx.memRead);
      chk("ex_mem_write", ex_mem_write, mEx.memWrite);
      chk("ex_alu_src", ex_alu_src, mEx.aluSrc);
      chk("ex_reg_dst", ex_reg_dst, mEx.regDst);
      chk("ex_alu_op", ex_alu_op, mEx.aluOp);
      if (mEx.valid) begin
         chk("ex_reg_rs", ex_reg_rs, mEx.rs);
         chk("ex_reg_rt", ex_reg_rt, mEx.rt);
         chk("ex_reg_rd", ex_reg_rd, mEx.rd);
         chk("ex_imm", ex_imm, mEx.imm);
         chk("ex_rs_data", ex_rs_data, mEx.rsData);
         chk("ex_rt_data", ex_rt_data, mEx.rtData);
      end
      chk("stall_count", stall_count, mCnt);
   endtask

   // One ID cycle: drive, check combinational outputs, clock, check ID/EX
   task automatic step(input logic [31:0] ins, input logic ifv, input logic [31:0] pc4);
      logic        eSt, eTk;
      logic [31:0] eTg;
      exrec_t      nx;
      instruction = ins; if_valid = ifv; pc_4 = pc4;
      #2;
      predict(eSt, eTk, eTg, nx);
      sPcWrite = pc_write; sIfid = ifid_write; sTaken = branch_taken; sFlush = flush; sTarget = branch_target;
      chk("pc_write", pc_write, !eSt);
      chk("ifid_write", ifid_write, !eSt);
      chk("branch_taken", branch_taken, eTk);
      chk("flush", flush, eTk);
      if (eTk) chk("branch_target", branch_target, eTg);
      @(posedge clk);
      if (wb_reg_write && wb_reg != 0) rf[wb_reg] = wb_data;
      mEx = nx;
      if (eSt && mCnt < (1 << CW) - 1) mCnt++;
      #1;
      checkEx();
   endtask

   task automatic modelReset();
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      mEx = '0;
      mCnt = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; if_valid = 1'b0; instruction = 32'd0; pc_4 = 32'd0;
      wb_reg_write = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
      mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_reg = 5'd0; mem_alu_result = 32'd0;
      modelReset();
      vecs[0] = '{32'h0000_1820, 9'b110000110, 1'b0};  // add $3,$0,$0
      vecs[1] = '{32'h8C00_0004, 9'b111101000, 1'b0};  // lw
      vecs[2] = '{32'hAC00_0008, 9'b100011000, 1'b0};  // sw
      vecs[3] = '{32'h2000_0005, 9'b110001000, 1'b0};  // addi
      vecs[4] = '{32'h1000_0003, 9'b100000001, 1'b1};  // beq $0,$0
      vecs[5] = '{32'h0800_0010, 9'b100000000, 1'b1};  // j
      vecs[6] = '{32'hFC00_0000, 9'b100000000, 1'b0};  // unknown opcode
      #1;
      chk("rst_pc_write", pc_write, 1'b1);
      chk("rst_ifid_write", ifid_write, 1'b1);
      chk("rst_flush", flush, 1'b0);
      chk("rst_taken", branch_taken, 1'b0);
      chk("rst_ex_valid", ex_valid, 1'b0);
      chk("rst_stall_count", stall_count, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         step(vecs[i].ins, 1'b1, 32'h400);
         chk("tbl_ctrl", {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                          ex_alu_src, ex_reg_dst, ex_alu_op}, vecs[i].expCtrl);
         chk("tbl_taken", sTaken, vecs[i].expTaken);
      end

      // lw $8,0($1) ; add $9,$8,$2
      step(32'h8C28_0000, 1'b1, 32'h500);
      step(32'h0102_4820, 1'b1, 32'h504);
      chk("lu_pc_write", sPcWrite, 1'b0);
      chk("lu_ifid_write", sIfid, 1'b0);
      chk("lu_bubble", ex_valid, 1'b0);
      chk("lu_count", stall_count, 1);
      step(32'h0102_4820, 1'b1, 32'h504);
      chk("lu_resume", sPcWrite, 1'b1);
      chk("lu_add_valid", ex_valid, 1'b1);
      chk("lu_add_rd", ex_reg_rd, 9);
      chk("lu_count_hold", stall_count, 1);

      // write-through and $0
      wb_reg_write = 1'b1; wb_reg = 5'd3; wb_data = 32'h1234;
      step(32'h0060_5020, 1'b1, 32'h508);
      chk("wt_rs_data", ex_rs_data, 32'h1234);
      wb_reg = 5'd0; wb_data = 32'hDEAD;
      step(32'h0000_5020, 1'b1, 32'h50C);
      chk("wt_r0", ex_rs_data, 32'd0);
      wb_reg_write = 1'b0;
      step(32'h0060_5020, 1'b1, 32'h510);
      chk("wt_stored", ex_rs_data, 32'h1234);

      // beq $3,$3,-1 and j
      step(32'h1063_FFFF, 1'b1, 32'h100);
      chk("beq_taken", sTaken, 1'b1);
      chk("beq_flush", sFlush, 1'b1);
      chk("beq_target", sTarget, 32'h0000_00FC);
      step(32'h0800_0040, 1'b1, 32'h1000_0004);
      chk("j_taken", sTaken, 1'b1);
      chk("j_target", sTarget, 32'h1000_0100);

      // beq $4,$5 with MEM writing $4=7 from a non-load, $5=7 in the file
      wb_reg_write = 1'b1; wb_reg = 5'd5; wb_data = 32'd7;
      step(32'd0, 1'b0, 32'd0);
      wb_reg_write = 1'b0;
      mem_reg_write = 1'b1; mem_mem_read = 1'b0; mem_reg = 5'd4; mem_alu_result = 32'd7;
      step(32'h1085_0002, 1'b1, 32'h200);
`ifdef BRANCH_FWD_EN
      chk("fwd_no_stall", sPcWrite, 1'b1);
      chk("fwd_taken", sTaken, 1'b1);
      chk("fwd_target", sTarget, 32'h208);
`else
      chk("nofwd_stall", sPcWrite, 1'b0);
      chk("nofwd_not_taken", sTaken, 1'b0);
      chk("nofwd_no_flush", sFlush, 1'b0);
      mem_reg_write = 1'b0;
      wb_reg_write = 1'b1; wb_reg = 5'd4; wb_data = 32'd7;
      step(32'h1085_0002, 1'b1, 32'h200);
      chk("nofwd_resume", sPcWrite, 1'b1);
      chk("nofwd_taken", sTaken, 1'b1);
      chk("nofwd_target", sTarget, 32'h208);
`endif
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;

      // drive the stall counter into saturation
      for (int i = 0; i < 20; i++) begin
         step(32'h8C28_0000, 1'b1, 32'h600);
         step(32'h0102_4820, 1'b1, 32'h604);
         step(32'h0102_4820, 1'b1, 32'h604);
      end
      chk("stall_saturate", stall_count, (1 << CW) - 1);

      // reset mid-run, with a would-be branch stall presented
      wb_reg_write = 1'b1; wb_reg = 5'd5; wb_data = 32'h55;
      step(32'd0, 1'b0, 32'd0);
      wb_reg_write = 1'b0;
      mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_reg = 5'd6;
      instruction = 32'h10C6_0000; if_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_pc_write", pc_write, 1'b1);
      chk("mrst_ifid_write", ifid_write, 1'b1);
      chk("mrst_flush", flush, 1'b0);
      chk("mrst_taken", branch_taken, 1'b0);
      chk("mrst_ex_valid", ex_valid, 1'b0);
      chk("mrst_stall_count", stall_count, 0);
      modelReset();
      @(posedge clk);
      #1 chk("mrst_hold_valid", ex_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
      step(32'h00A0_5820, 1'b1, 32'h700);
      chk("mrst_r5_cleared", ex_rs_data, 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rIns = $urandom;
         rIns[31:26] = ops[$urandom_range(0, 6)];
         rIns[25:21] = 5'($urandom_range(0, 7));
         rIns[20:16] = 5'($urandom_range(0, 7));
         rIns[15:11] = 5'($urandom_range(0, 7));
         wb_reg_write   = 1'($urandom_range(0, 1));
         wb_reg         = 5'($urandom_range(0, 7));
         wb_data        = $urandom_range(0, 3);
         mem_reg_write  = 1'($urandom_range(0, 1));
         mem_mem_read   = 1'($urandom_range(0, 1));
         mem_reg        = 5'($urandom_range(0, 7));
         mem_alu_result = $urandom_range(0, 3);
         step(rIns, $urandom_range(0, 7) != 0, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
